// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - access mode codes, FSM states and strobe helper for the data memory.
package dm_pkg;

   typedef enum logic [3:0] {
      DM_WORD          = 4'd0,
      DM_HALF          = 4'd1,
      DM_BYTE          = 4'd2,
      DM_HALF_UNSIGNED = 4'd3,
      DM_BYTE_UNSIGNED = 4'd4
   } dm_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dm_state_e;

   function automatic logic [3:0] dm_strobe(input logic [3:0] mode, input logic [1:0] addr_lo);
      case (mode)
         DM_WORD:                            return 4'b1111;
         DM_HALF, DM_HALF_UNSIGNED:          return addr_lo[1] ? 4'b1100 : 4'b0011;
         DM_BYTE, DM_BYTE_UNSIGNED:          return 4'b0001 << addr_lo;
         default:                            return 4'b0000;
      endcase
   endfunction

   function automatic logic dm_mode_legal(input logic [3:0] mode);
      return mode inside {DM_WORD, DM_HALF, DM_BYTE, DM_HALF_UNSIGNED, DM_BYTE_UNSIGNED};
   endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - byte-lane strobe, store merge, load extension and misalign detect.
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [3:0]  mode_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] old_word_i,
   input  logic [31:0] rd_word_i,
   output logic [3:0]  strb_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [31:0] rep;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      strb_o = dm_strobe(mode_i, addr_lo_i);
      case (mode_i)
         DM_WORD:                   rep = wdata_i;
         DM_HALF, DM_HALF_UNSIGNED: rep = {2{wdata_i[15:0]}};
         default:                   rep = {4{wdata_i[7:0]}};
      endcase
      for (int i = 0; i < 4; i++) begin
         wword_o[8*i +: 8] = strb_o[i] ? rep[8*i +: 8] : old_word_i[8*i +: 8];
      end

      byte_v = rd_word_i[{addr_lo_i, 3'b000} +: 8];
      half_v = rd_word_i[{addr_lo_i[1], 4'b0000} +: 16];
      case (mode_i)
         DM_WORD:          rdata_o = rd_word_i;
         DM_HALF:          rdata_o = {{16{half_v[15]}}, half_v};
         DM_HALF_UNSIGNED: rdata_o = {16'h0000, half_v};
         DM_BYTE:          rdata_o = {{24{byte_v[7]}}, byte_v};
         DM_BYTE_UNSIGNED: rdata_o = {24'h000000, byte_v};
         default:          rdata_o = 32'h0000_0000;
      endcase

      misalign_o = ((mode_i == DM_WORD) && (addr_lo_i != 2'b00)) ||
                   (((mode_i == DM_HALF) || (mode_i == DM_HALF_UNSIGNED)) && addr_lo_i[0]);
   end

endmodule

// File: rtl/dm_wait_mem.sv
// rtl/dm_wait_mem.sv - wait-state data memory with valid/ready handshake.
// Define DM_TRACE_EN to print each committed store.
module dm_wait_mem
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [3:0]  req_mode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int          AW        = $clog2(4 * DEPTH_WORDS);
   localparam logic [2:0]  WAIT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [32:0] BYTE_CAP  = 33'(64'(DEPTH_WORDS) * 4);

   dm_state_e   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [3:0]  mode_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] mem [DEPTH_WORDS];

   logic        idle, exec, err, commit;
   logic        cur_we;
   logic [3:0]  cur_mode, strb;
   logic [31:0] cur_addr, cur_wdata, rd_word, wword, ld_data;
   logic        misalign;

   // With zero wait states the access executes in the accept cycle, before the latch holds it.
   assign idle      = (state_q == ST_IDLE);
   assign cur_we    = idle ? req_we    : we_q;
   assign cur_mode  = idle ? req_mode  : mode_q;
   assign cur_addr  = idle ? req_addr  : addr_q;
   assign cur_wdata = idle ? req_wdata : wdata_q;
   assign rd_word   = mem[cur_addr[AW-1:2]];

   dm_lane_unit u_lane (
      .mode_i     (cur_mode),
      .addr_lo_i  (cur_addr[1:0]),
      .wdata_i    (cur_wdata),
      .old_word_i (rd_word),
      .rd_word_i  (rd_word),
      .strb_o     (strb),
      .wword_o    (wword),
      .rdata_o    (ld_data),
      .misalign_o (misalign)
   );

   assign err    = misalign || ({1'b0, cur_addr} >= BYTE_CAP) || !dm_mode_legal(cur_mode);
   assign commit = exec && cur_we && !err && (strb != 4'b0000);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      exec    = 1'b0;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            if (WAIT_CYCLES > 0) begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LOAD;
            end else begin
               state_d = ST_RESP;
               exec    = 1'b1;
            end
         end
         ST_WAIT: if (cnt_q == 3'd0) begin
            state_d = ST_RESP;
            exec    = 1'b1;
         end else begin
            cnt_d = cnt_q - 3'd1;
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (exec) begin
         err_d   = err;
         rdata_d = (err || cur_we) ? 32'h0000_0000 : ld_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         rdata_q <= 32'h0000_0000;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         mode_q  <= 4'd0;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (idle && req_valid) begin
            we_q    <= req_we;
            mode_q  <= req_mode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

`ifdef DM_TRACE_EN
   logic [31:0] pc_q;
   logic [31:0] cur_pc;
   assign cur_pc = idle ? req_pc : pc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 pc_q <= 32'h0000_0000;
      else if (idle && req_valid) pc_q <= req_pc;
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         mem[cur_addr[AW-1:2]] <= wword;
         $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, wword);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^req_pc;

   always_ff @(posedge clk) begin
      if (commit) mem[cur_addr[AW-1:2]] <= wword;
   end
`endif

   assign req_ready = idle;
   assign busy      = !idle;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_wait_mem.sv
// tb/tb_dm_wait_mem.sv - directed scoreboard bench for dm_wait_mem (WAIT_CYCLES 2 and 3 instances).
module tb_dm_wait_mem;
   import dm_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [3:0]  req_mode  [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [31:0] req_pc    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        busy      [2];

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dm_wait_mem #(.DEPTH_WORDS(4096), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_mode(req_mode[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_pc(req_pc[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
   );

   dm_wait_mem #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_mode(req_mode[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_pc(req_pc[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_reset_outputs(input int u);
      chk("rst_req_ready", 32'(req_ready[u]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[u], 32'd0);
      chk("rst_rsp_err",   32'(rsp_err[u]), 32'd0);
      chk("rst_busy",      32'(busy[u]), 32'd0);
   endtask

   // Drives one request and returns #1 after its accept edge; inputs are then scrambled.
   task automatic issue(input int u, input logic we, input logic [3:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                        input bit track);
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
      req_valid[u] = 1'b1;
      req_we[u]    = we;
      req_mode[u]  = mode;
      req_addr[u]  = addr;
      req_wdata[u] = wdata;
      req_pc[u]    = 32'h0000_0400 + addr;
      if (track) sb.push_back('{rdata: exp_rd, err: exp_err});
      @(posedge clk);
      #1;
      req_valid[u] = 1'b0;
      req_we[u]    = 1'($urandom);
      req_mode[u]  = 4'($urandom);
      req_addr[u]  = $urandom;
      req_wdata[u] = $urandom;
   endtask

   task automatic collect(input int u, input int exp_lat);
      int   lat;
      exp_t e;
      lat = 1;
      while (rsp_valid[u] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         chk("rsp_rdata", rsp_rdata[u], e.rdata);
         chk("rsp_err",   32'(rsp_err[u]), 32'(e.err));
      end
      @(posedge clk);
      #1;
      chk("busy_after_consume", 32'(busy[u]), 32'd0);
   endtask

   task automatic acc(input int u, input logic we, input logic [3:0] mode, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      issue(u, we, mode, addr, wdata, exp_rd, exp_err, 1'b1);
      collect(u, (u == 0) ? 3 : 4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_mode[i] = 4'd0;
         req_addr[i] = 32'd0; req_wdata[i] = 32'd0; req_pc[i] = 32'd0; rsp_ready[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs(0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs(0);

      // word store/load and latency
      acc(0, 1'b1, DM_WORD, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
      acc(0, 1'b0, DM_WORD, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

      // byte store into existing word, signed and unsigned byte loads
      acc(0, 1'b1, DM_BYTE, 32'h13, 32'h0000_00A5, 32'h0, 1'b0);
      acc(0, 1'b0, DM_WORD, 32'h10, 32'h0, 32'hA534_5678, 1'b0);
      acc(0, 1'b0, DM_BYTE, 32'h13, 32'h0, 32'hFFFF_FFA5, 1'b0);
      acc(0, 1'b0, DM_BYTE_UNSIGNED, 32'h13, 32'h0, 32'h0000_00A5, 1'b0);
      acc(0, 1'b0, DM_BYTE_UNSIGNED, 32'h10, 32'h0, 32'h0000_0078, 1'b0);

      // half stores/loads and misaligned half
      acc(0, 1'b1, DM_WORD, 32'h20, 32'h1111_2222, 32'h0, 1'b0);
      acc(0, 1'b1, DM_HALF, 32'h22, 32'h0000_8001, 32'h0, 1'b0);
      acc(0, 1'b0, DM_HALF, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
      acc(0, 1'b0, DM_HALF_UNSIGNED, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
      acc(0, 1'b0, DM_HALF, 32'h21, 32'h0, 32'h0, 1'b1);
      acc(0, 1'b1, DM_HALF, 32'h21, 32'h0000_BEEF, 32'h0, 1'b1);
      acc(0, 1'b1, DM_WORD, 32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1);
      acc(0, 1'b0, DM_WORD, 32'h20, 32'h0, 32'h8001_2222, 1'b0);

      // out of range aliases onto word 0 if the range check is missing; illegal mode
      acc(0, 1'b1, DM_WORD, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
      acc(0, 1'b0, DM_WORD, 32'h4000, 32'h0, 32'h0, 1'b1);
      acc(0, 1'b1, DM_WORD, 32'h4000, 32'hDEAD_BEEF, 32'h0, 1'b1);
      acc(0, 1'b1, DM_BYTE, 32'h8000_0001, 32'h0000_0011, 32'h0, 1'b1);
      acc(0, 1'b0, DM_WORD, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
      acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b1);
      acc(0, 1'b1, 4'h7, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
      acc(0, 1'b0, DM_WORD, 32'h10, 32'h0, 32'hA534_5678, 1'b0);

      // response held for 5 cycles while a new request waits
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, DM_WORD, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
      n = 1;
      while (rsp_valid[0] !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hold_latency", 32'(n), 32'd3);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_mode[0]  = DM_WORD;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h0;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("hold_rsp_valid", 32'(rsp_valid[0]), 32'd1);
         chk("hold_rsp_rdata", rsp_rdata[0], 32'hA534_5678);
         chk("hold_req_ready", 32'(req_ready[0]), 32'd0);
      end
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("consume_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("consume_req_ready", 32'(req_ready[0]), 32'd1);
      sb.push_back('{rdata: 32'h8001_2222, err: 1'b0});
      @(posedge clk);
      #1;
      chk("late_accept_busy", 32'(busy[0]), 32'd1);
      req_valid[0] = 1'b0;
      collect(0, 3);

      // reset during WAIT on the WAIT_CYCLES=3 instance drops the store
      acc(1, 1'b1, DM_WORD, 32'h40, 32'h0000_0011, 32'h0, 1'b0);
      acc(1, 1'b0, DM_WORD, 32'h40, 32'h0, 32'h0000_0011, 1'b0);
      issue(1, 1'b1, DM_WORD, 32'h40, 32'h0000_0022, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("wait_busy", 32'(busy[1]), 32'd1);
      rst_n[1] = 1'b0;
      #1;
      chk_reset_outputs(1);
      @(negedge clk);
      rst_n[1] = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      acc(1, 1'b0, DM_WORD, 32'h40, 32'h0, 32'h0000_0011, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
